// File: rtl/udp_rx_parser.sv
// GMII receive-side UDP parser: strips preamble/Ethernet/IPv4/UDP headers, filters on board MAC/IP/port.
// Define UDP_RX_IP_CSUM_EN to drop frames whose IPv4 header checksum does not verify.
module udp_rx_parser #(
   parameter logic [47:0] BOARD_MAC  = 48'h00_0A_35_01_FE_C0,
   parameter logic [31:0] BOARD_IP   = 32'hC0A8_0002,
   parameter logic [15:0] BOARD_PORT = 16'd8080
) (
   input  logic        e_rxc,
   input  logic        reset_n,
   input  logic [7:0]  e_rxd,
   input  logic        e_rxdv,
   output logic [7:0]  data_o,
   output logic        data_o_valid,
   output logic        frame_done,
   output logic        frame_err,
   output logic [15:0] rx_data_length,
   output logic [15:0] rx_total_length,
   output logic [47:0] pc_mac,
   output logic [31:0] pc_ip,
   output logic [15:0] pc_port
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PREAMBLE = 3'd1,
      S_ETH_HDR  = 3'd2,
      S_IP_HDR   = 3'd3,
      S_UDP_HDR  = 3'd4,
      S_PAYLOAD  = 3'd5,
      S_DROP     = 3'd6
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic        mac_board, mac_bcast;
   logic [47:0] sh_mac;
   logic [31:0] sh_ip;
   logic [15:0] sh_port, sh_total, sh_len, pay_cnt;
   logic        valid_nxt, done_nxt, err_nxt, commit, hdr_ok, csum_ok;

   function automatic logic [7:0] mac_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    return BOARD_MAC[47:40];
         3'd1:    return BOARD_MAC[39:32];
         3'd2:    return BOARD_MAC[31:24];
         3'd3:    return BOARD_MAC[23:16];
         3'd4:    return BOARD_MAC[15:8];
         3'd5:    return BOARD_MAC[7:0];
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] ip_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return BOARD_IP[31:24];
         2'd1:    return BOARD_IP[23:16];
         2'd2:    return BOARD_IP[15:8];
         2'd3:    return BOARD_IP[7:0];
         default: return 8'h00;
      endcase
   endfunction

`ifdef UDP_RX_IP_CSUM_EN
   logic [15:0] csum;
   logic [7:0]  csum_hi;

   function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

   assign csum_ok = (ones_add(csum, {csum_hi, e_rxd}) == 16'hFFFF);

   // Header word accumulator, restarted whenever the IP header is not being received
   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) begin
         csum    <= 16'd0;
         csum_hi <= 8'd0;
      end else if (state != S_IP_HDR) begin
         csum    <= 16'd0;
      end else if (e_rxdv) begin
         if (!cnt[0]) csum_hi <= e_rxd;
         else         csum    <= ones_add(csum, {csum_hi, e_rxd});
      end
   end
`else
   assign csum_ok = 1'b1;
`endif

   // State register
   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state, per-byte header checks and output strobes
   always_comb begin
      state_nxt = state;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      commit    = 1'b0;
      hdr_ok    = 1'b1;
      case (state)
         S_IDLE: begin
            if (e_rxdv) state_nxt = (e_rxd == 8'h55) ? S_PREAMBLE : S_DROP;
            else        state_nxt = S_IDLE;
         end
         S_PREAMBLE: begin
            if (!e_rxdv)              state_nxt = S_IDLE;
            else if (e_rxd == 8'h55)  state_nxt = S_PREAMBLE;
            else if (e_rxd == 8'hD5)  state_nxt = S_ETH_HDR;
            else                      state_nxt = S_DROP;
         end
         S_ETH_HDR: begin
            case (cnt)
               5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5:
                  hdr_ok = (mac_board && (e_rxd == mac_byte(cnt[2:0]))) ||
                           (mac_bcast && (e_rxd == 8'hFF));
               5'd12:   hdr_ok = (e_rxd == 8'h08);
               5'd13:   hdr_ok = (e_rxd == 8'h00);
               default: hdr_ok = 1'b1;
            endcase
            if (!e_rxdv) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else if (!hdr_ok)      state_nxt = S_DROP;
            else if (cnt == 5'd13)     state_nxt = S_IP_HDR;
            else                       state_nxt = S_ETH_HDR;
         end
         S_IP_HDR: begin
            case (cnt)
               5'd0:                  hdr_ok = (e_rxd == 8'h45);
               5'd9:                  hdr_ok = (e_rxd == 8'h11);
               5'd16, 5'd17, 5'd18:   hdr_ok = (e_rxd == ip_byte(cnt[1:0]));
               5'd19:                 hdr_ok = (e_rxd == ip_byte(cnt[1:0])) && csum_ok;
               default:               hdr_ok = 1'b1;
            endcase
            if (!e_rxdv) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else if (!hdr_ok)      state_nxt = S_DROP;
            else if (cnt == 5'd19)     state_nxt = S_UDP_HDR;
            else                       state_nxt = S_IP_HDR;
         end
         S_UDP_HDR: begin
            case (cnt)
               5'd2:    hdr_ok = (e_rxd == BOARD_PORT[15:8]);
               5'd3:    hdr_ok = (e_rxd == BOARD_PORT[7:0]);
               5'd5:    hdr_ok = ({sh_len[7:0], e_rxd} >= 16'd8);
               default: hdr_ok = 1'b1;
            endcase
            if (!e_rxdv) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else if (!hdr_ok) begin
               state_nxt = S_DROP;
            end else if (cnt == 5'd7) begin
               commit = 1'b1;
               // An empty datagram completes here; trailing padding/FCS is swallowed by DROP
               if (sh_len == 16'd8) begin
                  done_nxt  = 1'b1;
                  state_nxt = S_DROP;
               end else begin
                  state_nxt = S_PAYLOAD;
               end
            end else begin
               state_nxt = S_UDP_HDR;
            end
         end
         S_PAYLOAD: begin
            if (!e_rxdv) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               valid_nxt = 1'b1;
               if (pay_cnt == 16'd1) begin
                  done_nxt  = 1'b1;
                  state_nxt = S_DROP;
               end else begin
                  state_nxt = S_PAYLOAD;
               end
            end
         end
         S_DROP: begin
            if (!e_rxdv) state_nxt = S_IDLE;
            else         state_nxt = S_DROP;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Byte counter within the current header and destination-MAC match tracking
   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= 5'd0;
         mac_board <= 1'b0;
         mac_bcast <= 1'b0;
      end else begin
         if (state_nxt != state) cnt <= 5'd0;
         else if (e_rxdv)        cnt <= cnt + 5'd1;
         if (state == S_PREAMBLE) begin
            mac_board <= 1'b1;
            mac_bcast <= 1'b1;
         end else if (state == S_ETH_HDR && e_rxdv && cnt < 5'd6) begin
            mac_board <= mac_board & (e_rxd == mac_byte(cnt[2:0]));
            mac_bcast <= mac_bcast & (e_rxd == 8'hFF);
         end
      end
   end

   // Shadow copies of source fields; only published once the whole header is accepted
   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) begin
         sh_mac   <= 48'd0;
         sh_ip    <= 32'd0;
         sh_port  <= 16'd0;
         sh_total <= 16'd0;
         sh_len   <= 16'd0;
      end else if (e_rxdv) begin
         if (state == S_ETH_HDR && cnt >= 5'd6 && cnt <= 5'd11) sh_mac <= {sh_mac[39:0], e_rxd};
         if (state == S_IP_HDR && (cnt == 5'd2 || cnt == 5'd3)) sh_total <= {sh_total[7:0], e_rxd};
         if (state == S_IP_HDR && cnt >= 5'd12 && cnt <= 5'd15) sh_ip <= {sh_ip[23:0], e_rxd};
         if (state == S_UDP_HDR && cnt <= 5'd1) sh_port <= {sh_port[7:0], e_rxd};
         if (state == S_UDP_HDR && (cnt == 5'd4 || cnt == 5'd5)) sh_len <= {sh_len[7:0], e_rxd};
      end
   end

   // Registered outputs and payload down-counter
   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) begin
         data_o          <= 8'd0;
         data_o_valid    <= 1'b0;
         frame_done      <= 1'b0;
         frame_err       <= 1'b0;
         rx_data_length  <= 16'd0;
         rx_total_length <= 16'd0;
         pc_mac          <= 48'd0;
         pc_ip           <= 32'd0;
         pc_port         <= 16'd0;
         pay_cnt         <= 16'd0;
      end else begin
         data_o_valid <= valid_nxt;
         frame_done   <= done_nxt;
         frame_err    <= err_nxt;
         if (valid_nxt) data_o <= e_rxd;
         if (commit) begin
            pc_mac          <= sh_mac;
            pc_ip           <= sh_ip;
            pc_port         <= sh_port;
            rx_total_length <= sh_total;
            rx_data_length  <= sh_len - 16'd8;
            pay_cnt         <= sh_len - 16'd8;
         end else if (state == S_PAYLOAD && e_rxdv) begin
            pay_cnt <= pay_cnt - 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed self-checking bench for udp_rx_parser; honours UDP_RX_IP_CSUM_EN when defined.
module tb_udp_rx_parser;
   localparam logic [47:0] BOARD_MAC  = 48'h00_0A_35_01_FE_C0;
   localparam logic [47:0] SRC_MAC    = 48'h11_22_33_44_55_66;
   localparam logic [47:0] SRC_MAC2   = 48'hA0_B1_C2_D3_E4_F5;
   localparam logic [31:0] SRC_IP     = 32'hC0A8_0003;
`ifdef UDP_RX_IP_CSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   logic        e_rxc = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  e_rxd = 8'h00;
   logic        e_rxdv = 1'b0;
   logic [7:0]  data_o;
   logic        data_o_valid, frame_done, frame_err;
   logic [15:0] rx_data_length, rx_total_length, pc_port;
   logic [47:0] pc_mac;
   logic [31:0] pc_ip;

   udp_rx_parser dut (
      .e_rxc(e_rxc), .reset_n(reset_n), .e_rxd(e_rxd), .e_rxdv(e_rxdv),
      .data_o(data_o), .data_o_valid(data_o_valid), .frame_done(frame_done), .frame_err(frame_err),
      .rx_data_length(rx_data_length), .rx_total_length(rx_total_length),
      .pc_mac(pc_mac), .pc_ip(pc_ip), .pc_port(pc_port)
   );

   always #4 e_rxc = ~e_rxc;

   int cyc = 0;
   always @(posedge e_rxc) cyc <= cyc + 1;

   // Output monitor: everything cumulative, tests take snapshots
   logic [7:0] rx_q[$];
   int         rx_cyc[$];
   int         done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
   logic       done_with_valid = 1'b0;
   always @(negedge e_rxc) begin
      if (data_o_valid) begin
         rx_q.push_back(data_o);
         rx_cyc.push_back(cyc);
      end
      if (frame_done) begin
         done_cnt        <= done_cnt + 1;
         done_cyc        <= cyc;
         done_with_valid <= data_o_valid;
      end
      if (frame_err) begin
         err_cnt <= err_cnt + 1;
         err_cyc <= cyc;
      end
   end

   int total = 0, bad = 0;
   logic [7:0] fr[$];
   int hdr_end_cyc, pay_cyc, low_cyc;
   int r0, d0, e0;

   task automatic build(input logic [47:0] dmac, input logic [47:0] smac, input logic [15:0] sport,
                        input logic [15:0] dport, input logic [15:0] ulen, input int npay, input bit bad_cs);
      logic [7:0]  ip[20];
      logic [15:0] tl, cs;
      logic [31:0] s;
      int plen;
      fr.delete();
      repeat (7) fr.push_back(8'h55);
      fr.push_back(8'hD5);
      for (int i = 0; i < 6; i++) fr.push_back(dmac[8*(5-i) +: 8]);
      for (int i = 0; i < 6; i++) fr.push_back(smac[8*(5-i) +: 8]);
      fr.push_back(8'h08); fr.push_back(8'h00);
      tl = 16'd20 + ulen;
      ip = '{8'h45, 8'h00, tl[15:8], tl[7:0], 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11, 8'h00, 8'h00,
             SRC_IP[31:24], SRC_IP[23:16], SRC_IP[15:8], SRC_IP[7:0], 8'hC0, 8'hA8, 8'h00, 8'h02};
      s = 32'd0;
      for (int i = 0; i < 10; i++) s = s + {16'd0, ip[2*i], ip[2*i+1]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      cs = ~s[15:0];
      if (bad_cs) cs = cs ^ 16'h0001;
      ip[10] = cs[15:8]; ip[11] = cs[7:0];
      for (int i = 0; i < 20; i++) fr.push_back(ip[i]);
      fr.push_back(sport[15:8]); fr.push_back(sport[7:0]);
      fr.push_back(dport[15:8]); fr.push_back(dport[7:0]);
      fr.push_back(ulen[15:8]);  fr.push_back(ulen[7:0]);
      fr.push_back(8'h00); fr.push_back(8'h00);
      for (int i = 0; i < npay; i++) fr.push_back(8'(i + 1));
      plen = 28 + npay;
      while (plen < 46) begin
         fr.push_back(8'hEE);
         plen++;
      end
      fr.push_back(8'hDE); fr.push_back(8'hAD); fr.push_back(8'hBE); fr.push_back(8'hEF);
   endtask

   task automatic send(input int nbytes, input int gap);
      for (int i = 0; i < nbytes; i++) begin
         @(negedge e_rxc);
         e_rxdv = 1'b1;
         e_rxd  = fr[i];
         if (i == 49) hdr_end_cyc = cyc;
         if (i == 50) pay_cyc = cyc;
      end
      @(negedge e_rxc);
      e_rxdv = 1'b0;
      e_rxd  = 8'h00;
      low_cyc = cyc;
      repeat (gap - 1) @(negedge e_rxc);
   endtask

   task automatic snap();
      r0 = rx_q.size(); d0 = done_cnt; e0 = err_cnt;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge e_rxc);
      total++; if (data_o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_o_valid); end
      total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_o); end
      total++; if ({frame_done, frame_err} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {frame_done, frame_err}); end
      total++; if ({rx_data_length, rx_total_length} !== 32'd0) begin bad++; $display("FAIL reset_len got=%h exp=0", {rx_data_length, rx_total_length}); end
      total++; if ({pc_mac, pc_ip, pc_port} !== 96'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", {pc_mac, pc_ip, pc_port}); end
      reset_n = 1'b1;
      repeat (2) @(negedge e_rxc);
   endtask

   task automatic test_valid();
      snap();
      build(BOARD_MAC, SRC_MAC, 16'h04D2, 16'd8080, 16'd12, 4, 1'b0);
      send(fr.size(), 4);
      total++; if (rx_q.size() - r0 !== 4) begin bad++; $display("FAIL valid_count got=%0d exp=4", rx_q.size() - r0); end
      for (int i = 0; i < 4; i++) begin
         total++; if (rx_q[r0+i] !== 8'(i + 1)) begin bad++; $display("FAIL valid_byte%0d got=%h exp=%h", i, rx_q[r0+i], 8'(i + 1)); end
      end
      total++; if (rx_cyc[r0] !== pay_cyc + 1) begin bad++; $display("FAIL valid_latency got=%0d exp=%0d", rx_cyc[r0], pay_cyc + 1); end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL valid_done got=%0d exp=1", done_cnt - d0); end
      total++; if (done_cyc !== rx_cyc[r0+3] || done_with_valid !== 1'b1) begin bad++; $display("FAIL valid_done_timing got=%0d exp=%0d", done_cyc, rx_cyc[r0+3]); end
      total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL valid_err got=%0d exp=0", err_cnt - e0); end
      total++; if (rx_data_length !== 16'd4) begin bad++; $display("FAIL valid_data_len got=%0d exp=4", rx_data_length); end
      total++; if (rx_total_length !== 16'd32) begin bad++; $display("FAIL valid_total_len got=%0d exp=32", rx_total_length); end
      total++; if (pc_mac !== SRC_MAC) begin bad++; $display("FAIL valid_pc_mac got=%h exp=%h", pc_mac, SRC_MAC); end
      total++; if (pc_ip !== SRC_IP) begin bad++; $display("FAIL valid_pc_ip got=%h exp=%h", pc_ip, SRC_IP); end
      total++; if (pc_port !== 16'h04D2) begin bad++; $display("FAIL valid_pc_port got=%h exp=04d2", pc_port); end
   endtask

   task automatic test_bad_port();
      snap();
      build(BOARD_MAC, SRC_MAC2, 16'h1111, 16'd8081, 16'd12, 4, 1'b0);
      send(fr.size(), 4);
      total++; if (rx_q.size() - r0 !== 0) begin bad++; $display("FAIL port_count got=%0d exp=0", rx_q.size() - r0); end
      total++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin bad++; $display("FAIL port_pulses got=%0d/%0d exp=0/0", done_cnt - d0, err_cnt - e0); end
      total++; if (pc_port !== 16'h04D2 || pc_mac !== SRC_MAC) begin bad++; $display("FAIL port_hold got=%h/%h exp=04d2/%h", pc_port, pc_mac, SRC_MAC); end
      total++; if (rx_data_length !== 16'd4) begin bad++; $display("FAIL port_len_hold got=%0d exp=4", rx_data_length); end
   endtask

   task automatic test_broadcast();
      snap();
      build(48'hFFFF_FFFF_FFFF, SRC_MAC2, 16'h2222, 16'd8080, 16'd26, 18, 1'b0);
      send(fr.size(), 4);
      total++; if (rx_q.size() - r0 !== 18) begin bad++; $display("FAIL bcast_count got=%0d exp=18", rx_q.size() - r0); end
      for (int i = 0; i < 18; i++) begin
         total++; if (rx_q[r0+i] !== 8'(i + 1)) begin bad++; $display("FAIL bcast_byte%0d got=%h exp=%h", i, rx_q[r0+i], 8'(i + 1)); end
      end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL bcast_done got=%0d exp=1", done_cnt - d0); end
      total++; if (pc_mac !== SRC_MAC2 || pc_port !== 16'h2222) begin bad++; $display("FAIL bcast_pc got=%h/%h exp=%h/2222", pc_mac, pc_port, SRC_MAC2); end
      total++; if (rx_total_length !== 16'd46) begin bad++; $display("FAIL bcast_total got=%0d exp=46", rx_total_length); end
   endtask

   task automatic test_abort();
      snap();
      build(BOARD_MAC, SRC_MAC, 16'h3333, 16'd8080, 16'd18, 10, 1'b0);
      send(52, 4);
      total++; if (rx_q.size() - r0 !== 2) begin bad++; $display("FAIL abort_count got=%0d exp=2", rx_q.size() - r0); end
      total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL abort_err got=%0d exp=1", err_cnt - e0); end
      total++; if (err_cyc !== low_cyc + 1) begin bad++; $display("FAIL abort_err_timing got=%0d exp=%0d", err_cyc, low_cyc + 1); end
      total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", done_cnt - d0); end
      total++; if (rx_data_length !== 16'd10) begin bad++; $display("FAIL abort_len got=%0d exp=10", rx_data_length); end
   endtask

   task automatic test_zero_len();
      snap();
      build(BOARD_MAC, SRC_MAC, 16'hBEEF, 16'd8080, 16'd8, 0, 1'b0);
      send(fr.size(), 4);
      total++; if (rx_q.size() - r0 !== 0) begin bad++; $display("FAIL zero_count got=%0d exp=0", rx_q.size() - r0); end
      total++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin bad++; $display("FAIL zero_pulses got=%0d/%0d exp=1/0", done_cnt - d0, err_cnt - e0); end
      total++; if (done_cyc !== hdr_end_cyc + 1 || done_with_valid !== 1'b0) begin bad++; $display("FAIL zero_done_timing got=%0d exp=%0d", done_cyc, hdr_end_cyc + 1); end
      total++; if (pc_port !== 16'hBEEF) begin bad++; $display("FAIL zero_pc_port got=%h exp=beef", pc_port); end
      total++; if (rx_data_length !== 16'd0 || rx_total_length !== 16'd28) begin bad++; $display("FAIL zero_len got=%0d/%0d exp=0/28", rx_data_length, rx_total_length); end
   endtask

   task automatic test_bad_mac();
      snap();
      build(48'h00_0A_35_01_FE_C1, SRC_MAC, 16'h4444, 16'd8080, 16'd12, 4, 1'b0);
      send(fr.size(), 4);
      total++; if (rx_q.size() - r0 !== 0) begin bad++; $display("FAIL mac_count got=%0d exp=0", rx_q.size() - r0); end
      total++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin bad++; $display("FAIL mac_pulses got=%0d/%0d exp=0/0", done_cnt - d0, err_cnt - e0); end
      total++; if (pc_port !== 16'hBEEF) begin bad++; $display("FAIL mac_hold got=%h exp=beef", pc_port); end
   endtask

   task automatic test_csum();
      int exp_n;
      exp_n = CS_EN ? 0 : 4;
      snap();
      build(BOARD_MAC, SRC_MAC, 16'h5555, 16'd8080, 16'd12, 4, 1'b1);
      send(fr.size(), 4);
      total++; if (rx_q.size() - r0 !== exp_n) begin bad++; $display("FAIL csum_count got=%0d exp=%0d", rx_q.size() - r0, exp_n); end
      total++; if (done_cnt - d0 !== (CS_EN ? 0 : 1) || err_cnt - e0 !== 0) begin bad++; $display("FAIL csum_pulses got=%0d/%0d", done_cnt - d0, err_cnt - e0); end
   endtask

   task automatic test_back_to_back();
      snap();
      build(BOARD_MAC, SRC_MAC, 16'h0A0A, 16'd8080, 16'd12, 4, 1'b0);
      send(fr.size(), 1);
      build(BOARD_MAC, SRC_MAC2, 16'h0B0B, 16'd8080, 16'd11, 3, 1'b0);
      send(fr.size(), 4);
      total++; if (rx_q.size() - r0 !== 7) begin bad++; $display("FAIL b2b_count got=%0d exp=7", rx_q.size() - r0); end
      for (int i = 0; i < 3; i++) begin
         total++; if (rx_q[r0+4+i] !== 8'(i + 1)) begin bad++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, rx_q[r0+4+i], 8'(i + 1)); end
      end
      total++; if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_done got=%0d exp=2", done_cnt - d0); end
      total++; if (pc_port !== 16'h0B0B || rx_data_length !== 16'd3) begin bad++; $display("FAIL b2b_pc got=%h/%0d exp=0b0b/3", pc_port, rx_data_length); end
   endtask

   task automatic test_reset_mid();
      build(BOARD_MAC, SRC_MAC, 16'h0C0C, 16'd8080, 16'd16, 8, 1'b0);
      for (int i = 0; i < 54; i++) begin
         @(negedge e_rxc);
         e_rxdv = 1'b1;
         e_rxd  = fr[i];
      end
      @(negedge e_rxc);
      reset_n = 1'b0;
      e_rxd   = fr[54];
      @(negedge e_rxc);
      e_rxd   = fr[55];
      total++; if (data_o_valid !== 1'b0 || pc_port !== 16'h0000 || rx_data_length !== 16'd0) begin bad++; $display("FAIL rstmid_outputs got=%b/%h/%0d exp=0/0/0", data_o_valid, pc_port, rx_data_length); end
      reset_n = 1'b1;
      snap();
      for (int i = 56; i < fr.size(); i++) begin
         @(negedge e_rxc);
         e_rxd = fr[i];
      end
      @(negedge e_rxc);
      e_rxdv = 1'b0;
      repeat (4) @(negedge e_rxc);
      total++; if (rx_q.size() - r0 !== 0 || done_cnt - d0 !== 0) begin bad++; $display("FAIL rstmid_tail got=%0d/%0d exp=0/0", rx_q.size() - r0, done_cnt - d0); end
      snap();
      send(fr.size(), 4);
      total++; if (rx_q.size() - r0 !== 8 || done_cnt - d0 !== 1) begin bad++; $display("FAIL rstmid_recover got=%0d/%0d exp=8/1", rx_q.size() - r0, done_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_valid();
      test_bad_port();
      test_broadcast();
      test_abort();
      test_zero_len();
      test_bad_mac();
      test_csum();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
